// File: rtl/uart_word_assembler.sv
//------------------------------------------------------------------------------
// Module      : uart_word_assembler
// Description : Packs UART bytes (LSB first) into memory words and writes them
//               to consecutive addresses 0..end_addr. Optional trailing XOR
//               checksum byte enabled by macro UART_WORD_CHECKSUM_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_word_assembler #(
    parameter int WORD_WIDTH = 24,
    parameter int ADDR_WIDTH = 12,
    parameter int UART_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  startN,
    input  logic [ADDR_WIDTH-1:0] end_addr,
    input  logic                  new_byte,
    input  logic [UART_WIDTH-1:0] byte_in,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_data,
    output logic                  busy,
    output logic                  done,
    output logic                  chk_err
);

    localparam int BYTES_PER_WORD = (WORD_WIDTH + UART_WIDTH - 1) / UART_WIDTH;
    localparam int c_CNT_W        = $clog2(BYTES_PER_WORD + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
`ifdef UART_WORD_CHECKSUM_EN
        CHECK   = 3'd3,
`endif
        DONE    = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic [ADDR_WIDTH-1:0] r_endAddr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [c_CNT_W-1:0]    r_byteCnt;
    logic [WORD_WIDTH-1:0] r_word;
    logic [c_CNT_W-1:0]    w_slot;
    logic [WORD_WIDTH-1:0] w_placed;
    logic                  w_arm;
    logic                  w_take;
    logic                  w_lastAddr;

    assign w_lastAddr = (r_addr == r_endAddr);
    // A byte arriving during WRITE is the first byte of the following word.
    assign w_slot     = (r_state == WRITE) ? '0 : r_byteCnt;

    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_byte
        for (genvar gb = 0; gb < UART_WIDTH; gb++) begin : g_bit
            if (gi * UART_WIDTH + gb < WORD_WIDTH) begin : g_keep
                assign w_placed[gi*UART_WIDTH+gb] =
                    (w_slot == c_CNT_W'(gi)) & byte_in[gb];
            end
        end
    end

`ifdef UART_WORD_CHECKSUM_EN
    logic [UART_WIDTH-1:0] r_csum;
    logic                  r_chkErr;
    logic                  w_csumCheck;
`endif

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_arm       = 1'b0;
        w_take      = 1'b0;
        mem_wr_en   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
`ifdef UART_WORD_CHECKSUM_EN
        w_csumCheck = 1'b0;
`endif
        case (r_state)
            IDLE, DONE: begin
                done = (r_state == DONE);
                if (!startN) begin
                    w_arm       = 1'b1;
                    w_stateNext = COLLECT;
                end
            end
            COLLECT: begin
                busy = 1'b1;
                if (new_byte) begin
                    w_take = 1'b1;
                    if (r_byteCnt == c_CNT_W'(BYTES_PER_WORD - 1)) begin
                        w_stateNext = WRITE;
                    end
                end
            end
            WRITE: begin
                busy      = 1'b1;
                mem_wr_en = 1'b1;
                if (w_lastAddr) begin
`ifdef UART_WORD_CHECKSUM_EN
                    w_csumCheck = new_byte;
                    w_stateNext = new_byte ? DONE : CHECK;
`else
                    w_stateNext = DONE;
`endif
                end else begin
                    w_take      = new_byte;
                    w_stateNext = (new_byte && BYTES_PER_WORD == 1) ? WRITE : COLLECT;
                end
            end
`ifdef UART_WORD_CHECKSUM_EN
            CHECK: begin
                busy = 1'b1;
                if (new_byte) begin
                    w_csumCheck = 1'b1;
                    w_stateNext = DONE;
                end
            end
`endif
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_endAddr <= '0;
            r_addr    <= '0;
            r_byteCnt <= '0;
            r_word    <= '0;
        end else if (w_arm) begin
            r_endAddr <= end_addr;
            r_addr    <= '0;
            r_byteCnt <= '0;
            r_word    <= '0;
        end else if (r_state == WRITE && !w_lastAddr) begin
            r_addr    <= r_addr + ADDR_WIDTH'(1);
            r_byteCnt <= w_take ? c_CNT_W'(1) : '0;
            r_word    <= w_take ? w_placed : '0;
        end else if (w_take) begin
            r_byteCnt <= r_byteCnt + c_CNT_W'(1);
            r_word    <= r_word | w_placed;
        end
    end

`ifdef UART_WORD_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_csum   <= '0;
            r_chkErr <= 1'b0;
        end else if (w_arm) begin
            r_csum   <= '0;
            r_chkErr <= 1'b0;
        end else begin
            if (w_take) begin
                r_csum <= r_csum ^ byte_in;
            end
            if (w_csumCheck) begin
                r_chkErr <= (byte_in != r_csum);
            end
        end
    end

    assign chk_err = r_chkErr;
`else
    assign chk_err = 1'b0;
`endif

    assign mem_addr = r_addr;
    assign mem_data = r_word;

endmodule

`default_nettype wire

// File: doc/uart_word_assembler.md
UART_WORD_ASSEMBLER -- requirements
Module: uart_word_assembler

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 24, memory word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, memory address width in bits.
REQ-003 SHALL have parameter UART_WIDTH, default 8, received byte width in bits.
REQ-004 SHALL derive BYTES_PER_WORD = ceil(WORD_WIDTH/UART_WIDTH), which is 3 at defaults.
REQ-005 SHALL have port clk, input, 1 bit: clock, rising-edge.
REQ-006 SHALL have port rstN, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port startN, input, 1 bit: active-low arm request.
REQ-008 SHALL have port end_addr, input, ADDR_WIDTH bits: last address to write, sampled at arm.
REQ-009 SHALL have port new_byte, input, 1 bit: one-cycle strobe that validates byte_in.
REQ-010 SHALL have port byte_in, input, UART_WIDTH bits: received UART byte.
REQ-011 SHALL have port mem_wr_en, output, 1 bit: memory write strobe.
REQ-012 SHALL have port mem_addr, output, ADDR_WIDTH bits: memory write address.
REQ-013 SHALL have port mem_data, output, WORD_WIDTH bits: assembled word.
REQ-014 SHALL have port busy, output, 1 bit: high while armed and not done.
REQ-015 SHALL have port done, output, 1 bit: high from load completion until the next arm.
REQ-016 SHALL have port chk_err, output, 1 bit: checksum mismatch flag.

Function
REQ-017 SHALL implement states IDLE, COLLECT, WRITE, CHECK and DONE.
REQ-018 IDLE or DONE with startN=0 SHALL latch end_addr, clear address, byte count, word register and checksum, clear done and chk_err, and enter COLLECT next cycle.
REQ-019 startN SHALL be ignored in COLLECT, WRITE and CHECK.
REQ-020 new_byte in IDLE or DONE SHALL be ignored.
REQ-021 In COLLECT, each new_byte SHALL place byte_in at word bit offset byte_cnt*UART_WIDTH (LSB byte first) and increment byte_cnt.
REQ-022 Bits of the final byte beyond WORD_WIDTH SHALL be discarded.
REQ-023 On the BYTES_PER_WORD-th byte, the FSM SHALL enter WRITE on the next cycle.
REQ-024 WRITE SHALL last exactly one cycle, with mem_wr_en=1, mem_addr=current address and mem_data=assembled word.
REQ-025 In WRITE, if address==end_addr the FSM SHALL go to CHECK (macro defined) or DONE; otherwise it SHALL increment address, reset byte_cnt and return to COLLECT.
REQ-026 A new_byte coincident with WRITE SHALL be accepted as byte 0 of the next word and SHALL NOT be lost.
REQ-027 A new_byte coincident with WRITE of the last word SHALL be accepted as the checksum byte when the macro is defined, and discarded otherwise.
REQ-028 mem_wr_en SHALL be 0 in every state other than WRITE.
REQ-029 The address SHALL NOT wrap: end_addr=2^ADDR_WIDTH-1 SHALL terminate at that address.
REQ-030 end_addr=0 SHALL load exactly one word.
REQ-031 busy SHALL be 1 in COLLECT, WRITE and CHECK, and 0 otherwise.
REQ-032 done SHALL be 1 in DONE only.

Reset
REQ-033 rstN=0 at a clock edge SHALL force IDLE, regardless of state, including mid-word.
REQ-034 Reset SHALL clear all outputs, mem_addr, mem_data, byte_cnt and the checksum to 0.
REQ-035 Reset SHALL discard any partial word without writing it.

Configuration
REQ-036 Macro UART_WORD_CHECKSUM_EN SHALL control the checksum feature.
REQ-037 With UART_WORD_CHECKSUM_EN defined, the block SHALL keep a running XOR of all data bytes.
REQ-038 With UART_WORD_CHECKSUM_EN defined, CHECK SHALL wait for one further byte and compare it to the running XOR.
REQ-039 With UART_WORD_CHECKSUM_EN defined, a mismatch SHALL set chk_err=1 on entering DONE; a match SHALL leave chk_err=0.
REQ-040 With UART_WORD_CHECKSUM_EN undefined, the CHECK state and XOR logic SHALL be absent, chk_err SHALL be tied 0, and the last WRITE SHALL go directly to DONE.

Verification
REQ-041 The bench SHALL cover: arm with end_addr=1, bytes 11,22,33,44,55,66 (hex) -> writes addr0=0x332211 and addr1=0x665544, then done=1 and busy=0.
REQ-042 The bench SHALL cover: end_addr=0, bytes 01,02,04 -> one write 0x040201; with macro, checksum 07 -> chk_err=0 and checksum 06 -> chk_err=1.
REQ-043 The bench SHALL cover: bytes AA,BB sent in IDLE, then arm and send 01,02,03 with end_addr=0 -> single write 0x030201, with no write containing AA or BB.
REQ-044 The bench SHALL cover: rstN=0 after 2 of 3 bytes -> no write, all outputs 0; re-arm with a full word -> correct write at addr0.
REQ-045 The bench SHALL cover: new_byte=55 in the same cycle as WRITE of addr0 -> 55 becomes bits[7:0] of the addr1 word.
REQ-046 The bench SHALL cover: startN pulsed during COLLECT -> no effect; startN pulsed in DONE -> done=0, address restarts at 0.
